// File: rtl/bus_pkg.sv
// Shared bus definitions: address map constants, device ids and arbiter states.
package bus_pkg;

  localparam int          ADDR_W      = 16;
  localparam logic [15:0] REGION_SIZE = 16'h1000;
  localparam int          MAX_REGION  = 6;

  typedef enum logic [2:0] {
    DID_DRAM  = 3'd0,
    DID_DROM  = 3'd1,
    DID_DMAT  = 3'd2,
    DID_DINT  = 3'd3,
    DID_DREG  = 3'd4,
    DID_DEXEC = 3'd5,
    DID_DSPI  = 3'd6,
    DID_NONE  = 3'd7
  } did_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  function automatic logic [3:0] region_of(input logic [ADDR_W-1:0] addr);
    return 4'(addr / REGION_SIZE);
  endfunction

endpackage

// File: rtl/bus_decode.sv
// Address decode: maps the 4 KiB region of the bus address to a device id.
module bus_decode
  import bus_pkg::*;
(
  input  logic              bus_rd,
  input  logic              bus_wr,
  input  logic [ADDR_W-1:0] bus_addr,
  output logic              dec_hit,
  output logic [2:0]        dec_did
);

  logic [3:0] region;

  assign region = region_of(bus_addr);

  always_comb begin
    dec_hit = 1'b0;
    dec_did = DID_NONE;
    if ((bus_rd || bus_wr) && (region <= 4'(MAX_REGION))) begin
      dec_hit = 1'b1;
      dec_did = region[2:0];
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above the pointer, wrapping.
module rr_arbiter #(
  parameter  int NREQ  = 3,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] pointer,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    // Walk offsets 1..NREQ so the pointer's own slot is considered last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(pointer) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        winner      = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared bus: grants, drives the access, waits for
// ready or timeout, and returns data/error to the owning requester.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 16,
  parameter int DATA_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*16-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        ack,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic                   bus_rd,
  output logic                   bus_wr,
  output logic [15:0]            bus_addr,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   dec_hit,
  input  logic [2:0]             dec_did,
  input  logic                   bus_ready,
  input  logic [DATA_W-1:0]      bus_rdata
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [ADDR_W-1:0] addr_slot  [NREQ];
  logic [DATA_W-1:0] wdata_slot [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      assign addr_slot[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_slot[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arb_state_t       state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] owner_reg;
  logic             we_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [NREQ-1:0]  rr_grant;
  logic [IDX_W-1:0] rr_winner;
  logic             rr_any;
  logic [NREQ-1:0]  owner_onehot;
  logic             rom_write;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .pointer (ptr_reg),
    .grant   (rr_grant),
    .winner  (rr_winner),
    .any_req (rr_any)
  );

  assign owner_onehot = NREQ'(1) << owner_reg;
  assign rom_write    = we_reg && (did_t'(dec_did) == DID_DROM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= IDX_W'(NREQ-1);
      owner_reg <= '0;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      gnt       <= '0;
      ack       <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (rr_any) begin
            owner_reg <= rr_winner;
            ptr_reg   <= rr_winner;
            we_reg    <= req_we[rr_winner];
            gnt       <= rr_grant;
            bus_rd    <= !req_we[rr_winner];
            bus_wr    <= req_we[rr_winner];
            bus_addr  <= addr_slot[rr_winner];
            bus_wdata <= wdata_slot[rr_winner];
            state_reg <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          gnt <= '0;
          // Decode answers combinationally, so misses and ROM writes abort here.
          if (!dec_hit || rom_write) begin
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            ack       <= owner_onehot;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg   <= '0;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_ready) begin
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            ack       <= owner_onehot;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_reg ? '0 : bus_rdata;
            state_reg <= ST_DONE;
          end else if (cnt_reg == CNT_W'(TIMEOUT-1)) begin
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            ack       <= owner_onehot;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          ack       <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with the real decode and a scripted device.
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int NREQ    = 3;
  localparam int TIMEOUT = 16;
  localparam int DATA_W  = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req, req_we;
  logic [NREQ*16-1:0]     req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt, ack;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;
  logic                   bus_rd, bus_wr;
  logic [15:0]            bus_addr;
  logic [DATA_W-1:0]      bus_wdata;
  logic                   dec_hit;
  logic [2:0]             dec_did;
  logic                   bus_ready;
  logic [DATA_W-1:0]      bus_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .dec_hit(dec_hit), .dec_did(dec_did),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  bus_decode u_dec (
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
    .dec_hit(dec_hit), .dec_did(dec_did)
  );

  typedef struct {
    int          id;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          ready_at;   // cycle (gnt = 1) whose end sees bus_ready; 0 = never
    logic [15:0] rdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_ack;    // cycle in which ack is expected
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_txn(input int n, input vec_t v);
    int t, strobes, bad;
    bit done;
    req_we = '0;
    req_we[v.id] = v.we;
    req_addr[v.id*16 +: 16]  = v.addr;
    req_wdata[v.id*16 +: 16] = v.wdata;
    req = '0;
    req[v.id] = 1'b1;
    bus_ready = 1'b0;
    bus_rdata = v.rdata;
    t = 0; strobes = 0; bad = 0; done = 1'b0;
    while (!done && t < 40) begin
      @(negedge clk);
      t++;
      if (bus_rd && bus_wr) bad++;
      if (ack == '0 && (rsp_err || rsp_rdata != '0)) bad++;
      if (bus_rd || bus_wr) strobes++;
      if (t == 1) begin
        check($sformatf("v%0d gnt", n), gnt, 64'(1) << v.id);
        check($sformatf("v%0d bus_addr", n), bus_addr, v.addr);
        check($sformatf("v%0d rd/wr", n), {bus_rd, bus_wr}, {!v.we, v.we});
        if (v.we) check($sformatf("v%0d bus_wdata", n), bus_wdata, v.wdata);
        req = '0;
      end else if (gnt != '0) begin
        bad++;
      end
      if (ack != '0) begin
        done = 1'b1;
        check($sformatf("v%0d ack", n), ack, 64'(1) << v.id);
        check($sformatf("v%0d ack cycle", n), t, v.exp_ack);
        check($sformatf("v%0d rsp_err", n), rsp_err, v.exp_err);
        check($sformatf("v%0d rsp_rdata", n), rsp_rdata, v.exp_rdata);
        check($sformatf("v%0d strobe cycles", n), strobes, v.exp_ack - 1);
      end
      bus_ready = (t == v.ready_at);
    end
    check($sformatf("v%0d ack seen", n), done, 1);
    check($sformatf("v%0d protocol", n), bad, 0);
    bus_ready = 1'b0;
    req_we = '0;
    $display("txn v%0d: id=%0d we=%0d addr=0x%04h -> ack@%0d err=%0d rdata=0x%04h",
             n, v.id, v.we, v.addr, t, rsp_err, rsp_rdata);
    @(negedge clk);
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g);
    g = '0;
    for (int i = 0; i < 20 && g == '0; i++) begin
      @(negedge clk);
      g = gnt;
    end
  endtask

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    int gq [$];
    int acks, bad, last_g;
    logic [NREQ-1:0] g;

    vecs[0] = '{0, 1'b0, 16'h0010, 16'h0000,  3, 16'hBEEF, 1'b0, 16'hBEEF,  4};
    vecs[1] = '{1, 1'b1, 16'h1ABC, 16'h1234,  0, 16'h0000, 1'b1, 16'h0000,  2};
    vecs[2] = '{2, 1'b0, 16'h7FFF, 16'h0000,  0, 16'h0000, 1'b1, 16'h0000,  2};
    vecs[3] = '{2, 1'b0, 16'hF000, 16'h0000,  0, 16'h0000, 1'b1, 16'h0000,  2};
    vecs[4] = '{0, 1'b0, 16'h6FFF, 16'h0000,  0, 16'h9999, 1'b1, 16'h0000, TIMEOUT+2};
    vecs[5] = '{0, 1'b0, 16'h6FFF, 16'h0000, TIMEOUT+1, 16'h1234, 1'b0, 16'h1234, TIMEOUT+2};
    vecs[6] = '{1, 1'b1, 16'h0100, 16'h55AA,  2, 16'h7777, 1'b0, 16'h0000,  3};
    vecs[7] = '{2, 1'b0, 16'h6000, 16'h0000,  2, 16'hA5A5, 1'b0, 16'hA5A5,  3};
    vecs[8] = '{1, 1'b0, 16'h1000, 16'h0000,  2, 16'h0F0F, 1'b0, 16'h0F0F,  3};

    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    #12;
    check("reset outputs", {gnt, ack, rsp_err, rsp_rdata, bus_rd, bus_wr, bus_addr, bus_wdata}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 9; n++) run_txn(n, vecs[n]);

    // All requesters contend continuously: strict 0,1,2 rotation.
    do_reset();
    req_we = '0;
    for (int i = 0; i < NREQ; i++) req_addr[i*16 +: 16] = 16'h4000;
    bus_ready = 1'b1;
    bus_rdata = 16'hC0DE;
    req = '1;
    acks = 0; bad = 0; last_g = -1;
    for (int c = 0; c < 60 && acks < 6; c++) begin
      @(negedge clk);
      if ($countones(gnt) > 1) bad++;
      if (gnt != '0) begin
        last_g = onehot_idx(gnt);
        gq.push_back(last_g);
      end
      if (ack != '0) begin
        acks++;
        if (onehot_idx(ack) != last_g || rsp_rdata != 16'hC0DE || rsp_err) bad++;
      end
    end
    req = '0;
    bus_ready = 1'b0;
    check("rr acks", acks, 6);
    check("rr protocol", bad, 0);
    for (int k = 0; k < 6; k++)
      check($sformatf("rr order %0d", k), (k < gq.size()) ? gq[k] : -1, k % 3);
    $display("txn rr: %0d grants, %0d acks", gq.size(), acks);
    @(negedge clk);

    // Asynchronous reset mid-WAIT, then pointer restart check.
    req_we = '0;
    req_addr[0 +: 16] = 16'h6FFF;
    req = 3'b001;
    wait_gnt(g);
    check("arst gnt", g, 3'b001);
    req = '0;
    repeat (3) @(negedge clk);
    check("arst pre rd", bus_rd, 1'b1);
    #2 rst = 1'b1;
    #1 check("arst drop", {bus_rd, bus_wr, gnt, ack}, 64'd0);
    @(negedge clk);
    check("arst held", {bus_rd, bus_wr, gnt, ack, rsp_err}, 64'd0);
    rst = 1'b0;
    req_addr[0 +: 16]  = 16'h4000;
    req_addr[16 +: 16] = 16'h4000;
    bus_ready = 1'b1;
    req = 3'b011;
    wait_gnt(g);
    check("arst first gnt", g, 3'b001);
    req = 3'b010;
    wait_gnt(g);
    check("arst second gnt", g, 3'b010);
    req = '0;
    $display("txn arst: post-reset grants checked");
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
